// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the mainboard debug/loader bus.
// Holds the bus widths, the arbiter state encoding, the fill byte returned on
// a watchdog termination, and a helper that decodes arbiter state into the
// one-hot grant vector.
package wb_pkg;

  localparam int WB_ADR_BITS = 24;
  localparam int WB_DAT_BITS = 8;
  localparam int WB_SEL_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [WB_DAT_BITS-1:0] WD_FILL_DATA = 8'hFF;

  // {m1,m0} one-hot owner; idle (or any unused encoding) grants nobody
  function automatic logic [1:0] state_to_grant(input arb_state_e st);
    logic [1:0] g;
    case (st)
      ST_OWN0: g = 2'b01;
      ST_OWN1: g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Per-transfer watchdog for the Wishbone arbiter.
// Counts clock cycles that the current owner's strobe stays unacknowledged and
// fires once the strobe has waited TIMEOUT_CYCLES cycles.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   stb_i        : owner cyc & stb (strobe before any forced termination)
//   ack_i        : slave acknowledge
//   fire_o       : terminate the current strobe this cycle
module wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic stb_i,
  input  logic ack_i,
  output logic fire_o
);

  localparam logic [7:0] FIRE_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // A real ack in the firing cycle wins, so the slave's data is delivered normally
  assign fire_o = (cnt_q == FIRE_CNT) && stb_i && !ack_i;

  // Next count: restart on idle strobe, ack or fire; otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (!stb_i || ack_i || fire_o) begin
      cnt_d = 8'd0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter with per-transfer watchdog.
// m0 = overlay/monitor CPU, m1 = image loader. Ownership is decided one cycle
// after cyc rises and is held for the whole (possibly multi-beat) cycle.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   m0_* / m1_*            : master-side Wishbone (adr bit 0 = MSB)
//   s_*                    : slave-side Wishbone
//   grant_o                : {m1,m0} one-hot owner, 00 when idle
//   timeout_flag_o         : sticky watchdog-termination flag
//   timeout_clr_i          : clears timeout_flag_o (a new timeout wins)
module wb_dual_master_arbiter
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit M0_PRIORITY    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [0:WB_ADR_BITS-1] m0_adr_i,
  input  logic [WB_DAT_BITS-1:0] m0_dat_i,
  output logic [WB_DAT_BITS-1:0] m0_dat_o,
  input  logic                   m0_we_i,
  input  logic [WB_SEL_BITS-1:0] m0_sel_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_cyc_i,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  input  logic [0:WB_ADR_BITS-1] m1_adr_i,
  input  logic [WB_DAT_BITS-1:0] m1_dat_i,
  output logic [WB_DAT_BITS-1:0] m1_dat_o,
  input  logic                   m1_we_i,
  input  logic [WB_SEL_BITS-1:0] m1_sel_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_cyc_i,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  output logic [0:WB_ADR_BITS-1] s_adr_o,
  output logic [WB_DAT_BITS-1:0] s_dat_o,
  output logic                   s_we_o,
  output logic [WB_SEL_BITS-1:0] s_sel_o,
  output logic                   s_stb_o,
  output logic                   s_cyc_o,
  input  logic [WB_DAT_BITS-1:0] s_dat_i,
  input  logic                   s_ack_i,
  output logic [1:0]             grant_o,
  output logic                   timeout_flag_o,
  input  logic                   timeout_clr_i
);

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;  // 1 = m1 was the last owner
  logic       tflag_q, tflag_d;
  logic       owner_cyc_s;
  logic       owner_stb_s;
  logic       wd_fire_s;

  assign grant_o        = state_to_grant(state_q);
  assign timeout_flag_o = tflag_q;

  // Arbitration: next owner and round-robin history
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // Round-robin: the master that did not own the bus last goes first
          if (M0_PRIORITY || last_owner_q) begin
            state_d = ST_OWN0;
          end else begin
            state_d = ST_OWN1;
          end
        end else if (m0_cyc_i) begin
          state_d = ST_OWN0;
        end else if (m1_cyc_i) begin
          state_d = ST_OWN1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          last_owner_d = 1'b0;
          state_d      = m1_cyc_i ? ST_OWN1 : ST_IDLE;
        end else begin
          state_d = ST_OWN0;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          last_owner_d = 1'b1;
          state_d      = m0_cyc_i ? ST_OWN0 : ST_IDLE;
        end else begin
          state_d = ST_OWN1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbiter state, round-robin history and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      tflag_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      tflag_q      <= tflag_d;
    end
  end

  // Sticky flag: a firing watchdog beats a simultaneous clear
  always_comb begin
    if (wd_fire_s) begin
      tflag_d = 1'b1;
    end else if (timeout_clr_i) begin
      tflag_d = 1'b0;
    end else begin
      tflag_d = tflag_q;
    end
  end

  // Owner's raw cyc/stb, kept apart from the output mux so the watchdog input
  // never depends on the watchdog output
  always_comb begin
    owner_cyc_s = 1'b0;
    owner_stb_s = 1'b0;
    case (state_q)
      ST_OWN0: begin
        owner_cyc_s = m0_cyc_i;
        owner_stb_s = m0_cyc_i & m0_stb_i;
      end
      ST_OWN1: begin
        owner_cyc_s = m1_cyc_i;
        owner_stb_s = m1_cyc_i & m1_stb_i;
      end
      default: begin
        owner_cyc_s = 1'b0;
        owner_stb_s = 1'b0;
      end
    endcase
  end

  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .stb_i  (owner_stb_s),
    .ack_i  (s_ack_i),
    .fire_o (wd_fire_s)
  );

  // Slave-side and master-side muxing from the registered grant
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_cyc_o  = owner_cyc_s;
    s_stb_o  = owner_stb_s & ~wd_fire_s;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      ST_OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        // An ack arriving after the owner dropped cyc is not passed on
        m0_ack_o = (m0_cyc_i & s_ack_i) | wd_fire_s;
        m0_err_o = wd_fire_s;
        m0_dat_o = wd_fire_s ? WD_FILL_DATA : s_dat_i;
      end
      ST_OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = (m1_cyc_i & s_ack_i) | wd_fire_s;
        m1_err_o = wd_fire_s;
        m1_dat_o = wd_fire_s ? WD_FILL_DATA : s_dat_i;
      end
      default: begin
        s_adr_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for wb_dual_master_arbiter. Two instances share the stimulus:
// dut (round-robin, TIMEOUT_CYCLES=16) and dut_p (M0_PRIORITY=1, default timeout).
module tb_wb_dual_master_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] m0_adr, m1_adr;
  logic [7:0]  m0_dat, m1_dat, s_dat;
  logic        m0_we, m0_sel, m0_stb, m0_cyc;
  logic        m1_we, m1_sel, m1_stb, m1_cyc;
  logic        s_ack, t_clr;

  logic [7:0]  m0_dat_o, m1_dat_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [23:0] s_adr_o;
  logic        s_we_o, s_sel_o, s_stb_o, s_cyc_o, tflag;
  logic [1:0]  grant;

  logic [7:0]  p_m0_dat_o, p_m1_dat_o, p_s_dat_o;
  logic        p_m0_ack_o, p_m0_err_o, p_m1_ack_o, p_m1_err_o;
  logic [23:0] p_s_adr_o;
  logic        p_s_we_o, p_s_sel_o, p_s_stb_o, p_s_cyc_o, p_tflag;
  logic [1:0]  p_grant;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_dual_master_arbiter #(.TIMEOUT_CYCLES(16), .M0_PRIORITY(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .grant_o(grant), .timeout_flag_o(tflag), .timeout_clr_i(t_clr)
  );

  wb_dual_master_arbiter #(.M0_PRIORITY(1'b1)) dut_p (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(p_m0_dat_o), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(p_m0_ack_o),
    .m0_err_o(p_m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(p_m1_dat_o), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(p_m1_ack_o),
    .m1_err_o(p_m1_err_o),
    .s_adr_o(p_s_adr_o), .s_dat_o(p_s_dat_o), .s_we_o(p_s_we_o), .s_sel_o(p_s_sel_o),
    .s_stb_o(p_s_stb_o), .s_cyc_o(p_s_cyc_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .grant_o(p_grant), .timeout_flag_o(p_tflag), .timeout_clr_i(t_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    m0_adr = 24'h0; m0_dat = 8'h0; m0_we = 1'b0; m0_sel = 1'b1; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = 24'h0; m1_dat = 8'h0; m1_we = 1'b0; m1_sel = 1'b1; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_dat = 8'hC3; s_ack = 1'b0; t_clr = 1'b0;

    // Reset values
    step(); step();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
    chk("rst_m0_dat", m0_dat_o, 8'h00);
    chk("rst_acks", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'h0);
    chk("rst_flag", tflag, 1'b0);
    reset_n = 1'b1;

    // 1: m0 read, slave acks on the third strobe cycle
    step();
    m0_adr = 24'h010000; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    chk("t1_idle_latency", {grant, s_stb_o}, 3'b000);
    step();
    chk("t1_grant", grant, 2'b01);
    chk("t1_s_adr", s_adr_o, 24'h010000);
    chk("t1_s_stb", {s_cyc_o, s_stb_o, s_we_o}, 3'b110);
    step();
    step();
    s_ack = 1'b1; s_dat = 8'h5A;
    #1;
    chk("t1_m0_ack", {m0_ack_o, m0_err_o}, 2'b10);
    chk("t1_m0_dat", m0_dat_o, 8'h5A);
    chk("t1_m1_side", {m1_ack_o, m1_dat_o}, 9'h000);
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    chk("t1_idle", grant, 2'b00);

    // 2/3: tie from reset, direct handovers, then a second tie
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    m0_adr = 24'h000123; m1_adr = 24'h00ABCD;
    step();
    chk("t2_tie_rr", grant, 2'b01);
    chk("t3_tie_pri", p_grant, 2'b01);
    chk("t2_s_adr_m0", s_adr_o, 24'h000123);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    chk("t2_drop_same_cyc", {s_cyc_o, s_stb_o}, 2'b00);
    step();
    chk("t2_handover", grant, 2'b10);
    chk("t2_s_adr_m1", s_adr_o, 24'h00ABCD);
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    chk("t2_handback", grant, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    chk("t2_idle", grant, 2'b00);
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    chk("t2_tie2_rr", grant, 2'b10);
    chk("t3_tie2_pri", p_grant, 2'b01);
    step();
    chk("t3_pri_hold", p_grant, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    chk("t3_pri_m1", p_grant, 2'b10);
    chk("t2_rr_hold", grant, 2'b10);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    chk("t3_idle", {grant, p_grant}, 4'b0000);

    // 4: m0 write never acked, watchdog fires on the 16th strobe cycle
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 8'h33; s_dat = 8'h12;
    step();
    chk("t4_grant", grant, 2'b01);
    chk("t4_s_wr", {s_we_o, s_dat_o}, 9'h133);
    for (int i = 0; i < 14; i++) step();
    chk("t4_cycle15", {m0_ack_o, m0_err_o, s_stb_o}, 3'b001);
    step();
    chk("t4_fire", {m0_ack_o, m0_err_o, s_stb_o, s_cyc_o}, 4'b1101);
    chk("t4_fill", m0_dat_o, 8'hFF);
    chk("t4_flag_pre", tflag, 1'b0);
    chk("t4_pri_nofire", p_m0_ack_o, 1'b0);
    step();
    chk("t4_after", {m0_ack_o, tflag, s_stb_o}, 3'b011);
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    step();
    chk("t4_sticky", tflag, 1'b1);
    t_clr = 1'b1;
    step();
    t_clr = 1'b0;
    chk("t4_clear", tflag, 1'b0);

    // 5: ack arrives exactly on the firing cycle
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    s_ack = 1'b1; s_dat = 8'h77;
    #1;
    chk("t5_ack", {m0_ack_o, m0_err_o, s_stb_o}, 3'b101);
    chk("t5_dat", m0_dat_o, 8'h77);
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    chk("t5_flag", tflag, 1'b0);
    step();

    // 6: reset in the middle of an m1 transfer
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    chk("t6_own1", {grant, s_stb_o}, 3'b101);
    s_ack = 1'b1; s_dat = 8'hAA;
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_grant", grant, 2'b00);
    chk("t6_rst_bus", {s_cyc_o, s_stb_o, s_adr_o}, 26'h0);
    chk("t6_rst_acks", {m0_ack_o, m1_ack_o, m1_dat_o}, 10'h000);
    step();
    s_ack = 1'b0;
    reset_n = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    chk("t6_tie_m0", grant, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
